// File: rtl/lc3b_types.sv
// Shared types for the LC-3b memory-port arbiter: bus widths and arbiter state encoding.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    LOCK_D = 2'd3
  } arb_state_t;

  localparam lc3b_mem_wmask WMASK_ALL = 2'b11;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of D grants made while instruction fetch was left waiting.
module arb_starve_counter #(
  parameter int LIMIT = 4,
  parameter int W     = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  logic [W-1:0] count;

  assign at_limit = (count == W'(LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_limit) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch (I) and data (D): D priority, starvation guard
// for fetch, and a lock that keeps the port with D across both halves of LDI/STI.
//
//   state  | meaning
//   IDLE   | no owner, arbitrate on next edge
//   BUSY_I | fetch access in flight
//   BUSY_D | data access in flight
//   LOCK_D | port reserved for D, nothing in flight
module mem_arbiter import lc3b_types::*; #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_read,
  input  lc3b_word      i_address,
  output logic          i_resp,
  output lc3b_word      i_rdata,
  input  logic          d_read,
  input  logic          d_write,
  input  logic          d_lock,
  input  lc3b_word      d_address,
  input  lc3b_word      d_wdata,
  input  lc3b_mem_wmask d_wmask,
  output logic          d_resp,
  output lc3b_word      d_rdata,
  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_word      pmem_address,
  output lc3b_word      pmem_wdata,
  output lc3b_mem_wmask pmem_wmask,
  input  lc3b_word      pmem_rdata,
  input  logic          pmem_resp,
  output logic          busy
);

  arb_state_t    state, state_nxt;
  lc3b_word      addr_q, wdata_q, i_rdata_q, d_rdata_q;
  lc3b_mem_wmask wmask_q;
  logic          write_q, lock_q;
  logic          d_req, grant_i, grant_d, starve_inc, starve_hit;

  assign d_req = d_read | d_write;

  arb_starve_counter #(.LIMIT(STARVE_LIMIT), .W(CNT_W)) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (starve_inc),
    .clr      (grant_i),
    .at_limit (starve_hit)
  );

  always_comb begin
    state_nxt  = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    starve_inc = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && !(i_read && starve_hit)) begin
          grant_d    = 1'b1;
          starve_inc = i_read;
          state_nxt  = BUSY_D;
        end else if (i_read) begin
          grant_i   = 1'b1;
          state_nxt = BUSY_I;
        end
      end
      // Lock grants never count toward starvation; fetch simply waits.
      LOCK_D: begin
        if (d_req) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_D;
        end else if (!d_lock) begin
          state_nxt = IDLE;
        end
      end
      BUSY_I: if (pmem_resp) state_nxt = IDLE;
      BUSY_D: if (pmem_resp) state_nxt = lock_q ? LOCK_D : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      write_q   <= 1'b0;
      lock_q    <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (grant_d) begin
        addr_q  <= d_address;
        wdata_q <= d_wdata;
        wmask_q <= d_wmask;
        write_q <= d_write & ~d_read;  // read wins if both are raised
        lock_q  <= d_lock;
      end else if (grant_i) begin
        addr_q  <= i_address;
        wdata_q <= '0;
        wmask_q <= WMASK_ALL;
        write_q <= 1'b0;
        lock_q  <= 1'b0;
      end
      if (i_resp) i_rdata_q <= pmem_rdata;
      if (d_resp) d_rdata_q <= pmem_rdata;
    end
  end

  assign busy         = (state == BUSY_I) || (state == BUSY_D);
  assign pmem_read    = busy & ~write_q;
  assign pmem_write   = busy & write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign pmem_wmask   = wmask_q;

  assign i_resp  = (state == BUSY_I) & pmem_resp;
  assign d_resp  = (state == BUSY_D) & pmem_resp;
  assign i_rdata = i_resp ? pmem_rdata : i_rdata_q;
  assign d_rdata = d_resp ? pmem_rdata : d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: requesters push expected accesses, a monitor with a
// transaction-level arbitration model pops and checks them at grant and completion.
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk, rst_n;
  logic        i_read, d_read, d_write, d_lock, pmem_resp;
  logic [15:0] i_address, d_address, d_wdata, pmem_rdata;
  logic [1:0]  d_wmask;
  logic        i_resp, d_resp, pmem_read, pmem_write, busy;
  logic [15:0] i_rdata, d_rdata, pmem_address, pmem_wdata;
  logic [1:0]  pmem_wmask;

  mem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_lock(d_lock), .d_address(d_address),
    .d_wdata(d_wdata), .d_wmask(d_wmask), .d_resp(d_resp), .d_rdata(d_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_wmask(pmem_wmask), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp), .busy(busy)
  );

  typedef struct packed {
    logic        is_d;
    logic        write;
    logic        lock;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  wmask;
  } txn_t;

  txn_t q_i[$];
  txn_t q_d[$];
  int total = 0;
  int bad   = 0;

  int          mem_lat_fixed  = 0;
  bit          mem_data_use   = 0;
  logic [15:0] mem_data_fixed = 16'h0;
  bit          mem_inject     = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout, expected a response within the bound", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_i(input logic [15:0] a);
    txn_t t;
    i_read    = 1'b1;
    i_address = a;
    t.is_d = 1'b0; t.write = 1'b0; t.lock = 1'b0;
    t.addr = a; t.wdata = 16'h0; t.wmask = 2'b11;
    q_i.push_back(t);
  endtask

  task automatic issue_d(input logic rd, input logic wr, input logic lk,
                         input logic [15:0] a, input logic [15:0] wd, input logic [1:0] wm);
    txn_t t;
    if (rd && wr) $display("note: protocol violation, d_read and d_write both set at %0t", $time);
    d_read = rd; d_write = wr; d_lock = lk;
    d_address = a; d_wdata = wd; d_wmask = wm;
    t.is_d = 1'b1; t.write = wr && !rd; t.lock = lk;
    t.addr = a; t.wdata = wd; t.wmask = wm;
    q_d.push_back(t);
  endtask

  task automatic drop_all();
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; d_lock = 1'b0;
    q_i.delete();
    q_d.delete();
  endtask

  // Returns the address of the next access to start and how many negedges it took.
  task automatic wait_start(input string name, output logic [15:0] addr, output int n);
    bit ok = 0;
    addr = 16'h0;
    n = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      n++;
      if (busy) begin
        ok = 1;
        addr = pmem_address;
        break;
      end
    end
    if (!ok) fail_timeout(name);
  endtask

  // mode 0: wait for i_resp, 1: d_resp, 2: either
  task automatic wait_resp(input string name, input int mode, output bit was_d);
    bit ok = 0;
    was_d = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if ((mode != 1 && i_resp) || (mode != 0 && d_resp)) begin
        ok = 1;
        was_d = d_resp;
        break;
      end
    end
    if (!ok) fail_timeout(name);
  endtask

  // Memory: answers each access after a fixed or random latency with one resp pulse.
  initial begin
    int wait_n;
    bit active;
    pmem_resp = 1'b0;
    pmem_rdata = 16'h0;
    active = 0;
    wait_n = 0;
    forever begin
      step();
      if (!rst_n) begin
        pmem_resp = 1'b0;
        active = 0;
      end else if (pmem_resp) begin
        pmem_resp = 1'b0;
        active = 0;
      end else if (mem_inject) begin
        pmem_resp = 1'b1;
        pmem_rdata = 16'hDEAD;
        mem_inject = 0;
      end else if (active) begin
        wait_n--;
        if (wait_n <= 0) begin
          pmem_resp = 1'b1;
          pmem_rdata = mem_data_use ? mem_data_fixed : 16'($urandom);
        end
      end else if (pmem_read || pmem_write) begin
        active = 1;
        wait_n = (mem_lat_fixed > 0) ? mem_lat_fixed : int'($urandom_range(4, 1));
      end
    end
  end

  // Monitor with reference model: who owns the port, lock, starvation tally.
  initial begin
    bit m_busy, m_first, m_lock, dq;
    int m_starve;
    txn_t cur;
    logic [15:0] last_i, last_d;
    m_busy = 0; m_first = 0; m_lock = 0; m_starve = 0;
    last_i = 16'h0; last_d = 16'h0; cur = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 0; m_first = 0; m_lock = 0; m_starve = 0;
        last_i = 16'h0; last_d = 16'h0;
        q_i.delete();
        q_d.delete();
        continue;
      end
      if (m_busy) begin
        if (m_first) begin
          m_first = 0;
          chk("grant_read", pmem_read, !cur.write);
          chk("grant_write", pmem_write, cur.write);
          chk("grant_addr", pmem_address, cur.addr);
          chk("grant_wmask", pmem_wmask, cur.wmask);
          if (cur.is_d) chk("grant_wdata", pmem_wdata, cur.wdata);
        end
        chk("busy_high", busy, 1'b1);
        if (pmem_resp) begin
          chk("i_resp", i_resp, !cur.is_d);
          chk("d_resp", d_resp, cur.is_d);
          if (cur.is_d) begin
            chk("d_rdata", d_rdata, pmem_rdata);
            chk("i_rdata_hold", i_rdata, last_i);
            last_d = pmem_rdata;
          end else begin
            chk("i_rdata", i_rdata, pmem_rdata);
            chk("d_rdata_hold", d_rdata, last_d);
            last_i = pmem_rdata;
          end
          m_busy = 0;
          m_lock = cur.is_d && cur.lock;
        end else begin
          chk("no_early_resp", {i_resp, d_resp}, 2'b00);
        end
      end else begin
        chk("idle_outputs", {busy, pmem_read, pmem_write, i_resp, d_resp}, 5'b0);
        dq = d_read || d_write;
        if (m_lock) begin
          if (dq) begin
            chk("d_queue_depth", q_d.size(), 1);
            if (q_d.size() > 0) begin cur = q_d.pop_front(); m_busy = 1; m_first = 1; end
          end else if (!d_lock) begin
            m_lock = 0;
          end
        end else if (dq && !(i_read && m_starve == LIMIT)) begin
          if (i_read) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
          chk("d_queue_depth", q_d.size(), 1);
          if (q_d.size() > 0) begin cur = q_d.pop_front(); m_busy = 1; m_first = 1; end
        end else if (i_read) begin
          m_starve = 0;
          chk("i_queue_depth", q_i.size(), 1);
          if (q_i.size() > 0) begin cur = q_i.pop_front(); m_busy = 1; m_first = 1; end
        end
      end
    end
  end

  initial begin
    logic [15:0] addr;
    int n;
    bit was_d;

    rst_n = 1'b0;
    i_read = 0; d_read = 0; d_write = 0; d_lock = 0;
    i_address = 0; d_address = 0; d_wdata = 0; d_wmask = 0;
    repeat (3) step();
    chk("reset_outputs", {busy, pmem_read, pmem_write, i_resp, d_resp}, 5'b0);
    chk("reset_rdata", {i_rdata, d_rdata}, 32'h0);
    rst_n = 1'b1;
    step();

    // single fetch, fixed 3-cycle memory
    mem_lat_fixed = 3; mem_data_use = 1; mem_data_fixed = 16'h1234;
    issue_i(16'h3000);
    @(negedge clk);
    @(negedge clk);
    chk("t1_pmem_read", pmem_read, 1'b1);
    chk("t1_addr", pmem_address, 16'h3000);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n++;
      if (i_resp) break;
    end
    chk("t1_latency", n, 3);
    chk("t1_rdata", i_rdata, 16'h1234);
    step();
    i_read = 0;
    @(negedge clk);
    chk("t1_idle_after", busy, 1'b0);
    mem_lat_fixed = 0; mem_data_use = 0;

    // simultaneous requests: D first, I next
    step();
    issue_i(16'h3010);
    issue_d(1, 0, 0, 16'h4010, 16'h0, 2'b11);
    wait_start("t2_start_d", addr, n);
    chk("t2_d_first", addr, 16'h4010);
    wait_resp("t2_resp_d", 1, was_d);
    step();
    d_read = 0;
    wait_start("t2_start_i", addr, n);
    chk("t2_i_next", addr, 16'h3010);
    chk("t2_i_latency", n, 2);
    wait_resp("t2_resp_i", 0, was_d);
    step();
    i_read = 0;

    // starvation guard: D D D D I, twice
    step();
    issue_i(16'h3020);
    issue_d(1, 0, 0, 16'h4020, 16'h0, 2'b11);
    for (int g = 0; g < 10; g++) begin
      wait_start("t3_start", addr, n);
      chk("t3_owner_is_d", addr[14], (g % 5) != 4);
      wait_resp("t3_resp", 2, was_d);
      step();
      if (g == 9) drop_all();
      else if (was_d) issue_d(1, 0, 0, 16'h4020 + 16'(g), 16'h0, 2'b11);
      else issue_i(16'h3020 + 16'(g));
    end

    // STI: locked write, hold, second write, then I
    step();
    issue_i(16'h3100);
    issue_d(0, 1, 1, 16'h4000, 16'h1111, 2'b11);
    wait_start("t4_start1", addr, n);
    chk("t4_first_d", addr, 16'h4000);
    chk("t4_first_write", pmem_write, 1'b1);
    wait_resp("t4_resp1", 1, was_d);
    step();
    d_write = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_lock_holds_i", {busy, pmem_read}, 2'b00);
    end
    step();
    issue_d(0, 1, 0, 16'h4002, 16'hBEEF, 2'b01);
    wait_start("t4_start2", addr, n);
    chk("t4_addr2", addr, 16'h4002);
    chk("t4_wmask", pmem_wmask, 2'b01);
    chk("t4_wdata", pmem_wdata, 16'hBEEF);
    wait_resp("t4_resp2", 1, was_d);
    step();
    d_write = 0;
    wait_start("t4_start_i", addr, n);
    chk("t4_i_after_lock", addr, 16'h3100);
    wait_resp("t4_resp_i", 0, was_d);
    step();
    i_read = 0;

    // read and write together: treated as read
    step();
    issue_d(1, 1, 0, 16'h4200, 16'h5555, 2'b10);
    wait_start("t6_start", addr, n);
    chk("t6_read", pmem_read, 1'b1);
    chk("t6_write", pmem_write, 1'b0);
    wait_resp("t6_resp", 1, was_d);
    step();
    d_read = 0; d_write = 0;

    // reset in the middle of a locked D access, then a stray resp
    step();
    mem_lat_fixed = 12;
    issue_d(1, 0, 1, 16'h4300, 16'h0, 2'b11);
    wait_start("t5_start", addr, n);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_drop", {pmem_read, pmem_write, busy}, 3'b000);
    chk("t5_no_d_resp", d_resp, 1'b0);
    drop_all();
    repeat (2) step();
    rst_n = 1'b1;
    mem_lat_fixed = 0;
    step();
    mem_inject = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_late_resp_ignored", {d_resp, i_resp, busy}, 3'b000);
    end
    step();
    issue_i(16'h3300);
    wait_start("t5_start_i", addr, n);
    chk("t5_lock_released", addr, 16'h3300);
    chk("t5_i_latency", n, 2);
    wait_resp("t5_resp_i", 0, was_d);
    step();
    i_read = 0;

    // random traffic from both requesters
    fork
      begin : i_proc
        bit wd;
        for (int t = 0; t < 30; t++) begin
          repeat ($urandom_range(3, 0)) step();
          issue_i(16'h3000 | 16'($urandom_range(4095, 0)));
          wait_resp("rand_i_resp", 0, wd);
          step();
          i_read = 0;
        end
      end
      begin : d_proc
        bit wd, chain, lk, rd;
        chain = 0;
        for (int t = 0; t < 30; t++) begin
          if (!chain) repeat ($urandom_range(3, 0)) step();
          lk = (t < 29) && ($urandom_range(3, 0) == 0);
          rd = 1'($urandom_range(1, 0));
          issue_d(rd, !rd, lk, 16'h4000 | 16'($urandom_range(4095, 0)),
                  16'($urandom), 2'($urandom_range(3, 1)));
          wait_resp("rand_d_resp", 1, wd);
          step();
          d_read = 0; d_write = 0; d_lock = 0;
          chain = lk;
        end
      end
    join

    repeat (5) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
